// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline control: opcodes, stall reasons and
// the hazard scoreboard slot format.
package wisc_pkg;

  localparam logic [4:0] OP_SIIC = 5'b00010;
  localparam logic [4:0] OP_RTI  = 5'b00011;

  typedef enum logic [1:0] {
    RSN_RUN    = 2'd0,
    RSN_HAZ    = 2'd1,
    RSN_FREEZE = 2'd2,
    RSN_FLUSH  = 2'd3
  } reason_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic       is_load;
  } sb_slot_t;

  localparam int unsigned SbSlotW = $bits(sb_slot_t);
  localparam sb_slot_t    SB_BUBBLE = '0;

  // True when a valid slot's destination is one of the decode sources.
  function automatic logic sb_match(input sb_slot_t s,
                                    input logic [2:0] rs, input logic rs_valid,
                                    input logic [2:0] rt, input logic rt_valid);
    return s.valid & ((rs_valid & (rs == s.rd)) | (rt_valid & (rt == s.rd)));
  endfunction

endpackage

// File: rtl/dff.sv
// Basic D flip-flop cell with synchronous active-high reset.
module dff #(
  parameter int unsigned      Width  = 1,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RstVal;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/sb_slot.sv
// One scoreboard stage: holds on a pipe freeze, loads a bubble on request,
// otherwise takes the upstream slot.
module sb_slot
  import wisc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     hold,
  input  logic     bubble,
  input  sb_slot_t d,
  output sb_slot_t q
);

  sb_slot_t             nxt;
  logic [SbSlotW-1:0]   q_bits;

  always_comb begin
    nxt = d;
    if (hold) begin
      nxt = q;
    end else if (bubble) begin
      nxt = SB_BUBBLE;
    end
  end

  dff #(.Width(SbSlotW)) u_q (
    .clk (clk),
    .rst (rst),
    .d   (nxt),
    .q   (q_bits)
  );

  assign q = sb_slot_t'(q_bits);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side hazard/stall controller: shadow scoreboard of in-flight
// destinations, flush on siic/rti/taken branch, freeze on memory stall.
module hazard_ctrl
  import wisc_pkg::*;
#(
  parameter bit FORWARD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_valid,
  input  logic        id_rt_valid,
  input  logic [2:0]  id_write_sel,
  input  logic        id_Reg_write,
  input  logic        id_Mem_read,
  input  logic [4:0]  ex_opcode,
  input  logic        branch_taken,
  input  logic        mem_stall,
  output logic        stall_decode,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        flush_fetch,
  output logic        freeze,
  output logic [1:0]  stall_reason,
  output logic [15:0] stall_cycles
);

  sb_slot_t    ex_q, mem_q, wb_q, ex_d;
  logic        match_ex, match_mem, hz, fl;
  reason_e     reason;
  logic [15:0] cycles_d;
  logic        unused_wb;

  assign ex_d = '{valid: id_Reg_write, rd: id_write_sel, is_load: id_Mem_read};

  sb_slot u_sb_ex (
    .clk    (clk),
    .rst    (rst),
    .hold   (mem_stall),
    .bubble (stall_decode | flush_fetch),
    .d      (ex_d),
    .q      (ex_q)
  );

  sb_slot u_sb_mem (
    .clk    (clk),
    .rst    (rst),
    .hold   (mem_stall),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  sb_slot u_sb_wb (
    .clk    (clk),
    .rst    (rst),
    .hold   (mem_stall),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // WB is tracked but never stalls: the register file writes before it reads.
  assign unused_wb = ^wb_q;

  assign match_ex  = sb_match(ex_q, id_rs, id_rs_valid, id_rt, id_rt_valid);
  assign match_mem = sb_match(mem_q, id_rs, id_rs_valid, id_rt, id_rt_valid);
  assign hz = FORWARD ? (match_ex & ex_q.is_load) : (match_ex | match_mem);
  assign fl = branch_taken | (ex_opcode == OP_SIIC) | (ex_opcode == OP_RTI);

  // Reset forces RUN so the outputs take their RUN values while rst is high.
  always_comb begin
    reason = RSN_RUN;
    if (rst) begin
      reason = RSN_RUN;
    end else if (mem_stall) begin
      reason = RSN_FREEZE;
    end else if (fl) begin
      reason = RSN_FLUSH;
    end else if (hz) begin
      reason = RSN_HAZ;
    end
  end

  always_comb begin
    stall_decode = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    flush_fetch  = 1'b0;
    freeze       = 1'b0;
    unique case (reason)
      RSN_FREEZE: begin
        freeze      = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end
      RSN_FLUSH: begin
        flush_fetch  = 1'b1;
        stall_decode = 1'b1;
      end
      RSN_HAZ: begin
        stall_decode = 1'b1;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    cycles_d = stall_cycles;
    if (reason != RSN_RUN && stall_cycles != 16'hFFFF) begin
      cycles_d = stall_cycles + 16'd1;
    end
  end

  dff #(.Width(2)) u_reason (
    .clk (clk),
    .rst (rst),
    .d   (reason),
    .q   (stall_reason)
  );

  dff #(.Width(16)) u_cycles (
    .clk (clk),
    .rst (rst),
    .d   (cycles_d),
    .q   (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; one instance with forwarding, one without.
module tb_hazard_ctrl;

  logic        clk, rst;
  logic [2:0]  id_rs, id_rt, id_write_sel;
  logic        id_rs_valid, id_rt_valid, id_Reg_write, id_Mem_read;
  logic [4:0]  ex_opcode;
  logic        branch_taken, mem_stall;

  logic        f_sd, f_pc, f_ifid, f_fl, f_fz;
  logic [1:0]  f_rsn;
  logic [15:0] f_cyc;
  logic        n_sd, n_pc, n_ifid, n_fl, n_fz;
  logic [1:0]  n_rsn;
  logic [15:0] n_cyc;

  wire [4:0] f_ctl = {f_sd, f_pc, f_ifid, f_fl, f_fz};
  wire [4:0] n_ctl = {n_sd, n_pc, n_ifid, n_fl, n_fz};

  // {stall_decode, pc_write, if_id_write, flush_fetch, freeze}
  localparam logic [4:0] C_RUN    = 5'b01100;
  localparam logic [4:0] C_HAZ    = 5'b10000;
  localparam logic [4:0] C_FLUSH  = 5'b11110;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  int vecs = 0;
  int errs = 0;

  hazard_ctrl #(.FORWARD(1'b1)) dut_fw (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
    .id_write_sel(id_write_sel), .id_Reg_write(id_Reg_write), .id_Mem_read(id_Mem_read),
    .ex_opcode(ex_opcode), .branch_taken(branch_taken), .mem_stall(mem_stall),
    .stall_decode(f_sd), .pc_write(f_pc), .if_id_write(f_ifid), .flush_fetch(f_fl),
    .freeze(f_fz), .stall_reason(f_rsn), .stall_cycles(f_cyc)
  );

  hazard_ctrl #(.FORWARD(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
    .id_write_sel(id_write_sel), .id_Reg_write(id_Reg_write), .id_Mem_read(id_Mem_read),
    .ex_opcode(ex_opcode), .branch_taken(branch_taken), .mem_stall(mem_stall),
    .stall_decode(n_sd), .pc_write(n_pc), .if_id_write(n_ifid), .flush_fetch(n_fl),
    .freeze(n_fz), .stall_reason(n_rsn), .stall_cycles(n_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs = 3'd0; id_rt = 3'd0; id_rs_valid = 1'b0; id_rt_valid = 1'b0;
    id_write_sel = 3'd0; id_Reg_write = 1'b0; id_Mem_read = 1'b0;
    ex_opcode = 5'd0; branch_taken = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic load_r3();
    id_write_sel = 3'd3; id_Reg_write = 1'b1; id_Mem_read = 1'b1;
    #1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    mem_stall = 1'b1;
    branch_taken = 1'b1;
    #1;
    if (f_ctl !== C_RUN) begin
      $display("FAIL rst_ctl_fw: got %b want %b", f_ctl, C_RUN); errs++;
    end
    vecs++;
    if (n_ctl !== C_RUN) begin
      $display("FAIL rst_ctl_nf: got %b want %b", n_ctl, C_RUN); errs++;
    end
    vecs++;
    if (f_rsn !== 2'd0 || f_cyc !== 16'd0) begin
      $display("FAIL rst_regs: got rsn %0d cyc %0d want 0 0", f_rsn, f_cyc); errs++;
    end
    vecs++;
    idle();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    reset_dut();
    load_r3();
    id_rs = 3'd3; id_rs_valid = 1'b1; id_write_sel = 3'd4; id_Mem_read = 1'b0;
    #1;
    if (f_ctl !== C_HAZ) begin
      $display("FAIL lu_haz_fw: got %b want %b", f_ctl, C_HAZ); errs++;
    end
    vecs++;
    if (n_ctl !== C_HAZ) begin
      $display("FAIL lu_haz_nf: got %b want %b", n_ctl, C_HAZ); errs++;
    end
    vecs++;
    step();
    #1;
    if (f_ctl !== C_RUN || f_rsn !== 2'd1 || f_cyc !== 16'd1) begin
      $display("FAIL lu_clear_fw: got %b/%0d/%0d want %b/1/1", f_ctl, f_rsn, f_cyc, C_RUN);
      errs++;
    end
    vecs++;
    if (n_ctl !== C_HAZ) begin
      $display("FAIL lu_second_nf: got %b want %b", n_ctl, C_HAZ); errs++;
    end
    vecs++;
    step();
    #1;
    if (f_rsn !== 2'd0 || f_cyc !== 16'd1) begin
      $display("FAIL lu_after_fw: got rsn %0d cyc %0d want 0 1", f_rsn, f_cyc); errs++;
    end
    vecs++;
    if (n_ctl !== C_RUN || n_rsn !== 2'd1 || n_cyc !== 16'd2) begin
      $display("FAIL lu_after_nf: got %b/%0d/%0d want %b/1/2", n_ctl, n_rsn, n_cyc, C_RUN);
      errs++;
    end
    vecs++;
    idle();
  endtask

  task automatic test_alu_raw();
    reset_dut();
    id_write_sel = 3'd2; id_Reg_write = 1'b1;
    #1;
    step();
    id_write_sel = 3'd0; id_Reg_write = 1'b0;
    id_rt = 3'd2; id_rt_valid = 1'b1; id_rs = 3'd5; id_rs_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (f_ctl !== C_RUN) begin
        $display("FAIL raw_fw_c%0d: got %b want %b", c, f_ctl, C_RUN); errs++;
      end
      vecs++;
      if (n_ctl !== C_HAZ) begin
        $display("FAIL raw_nf_c%0d: got %b want %b", c, n_ctl, C_HAZ); errs++;
      end
      vecs++;
      step();
    end
    #1;
    if (n_ctl !== C_RUN || n_rsn !== 2'd1 || n_cyc !== 16'd2 || f_cyc !== 16'd0) begin
      $display("FAIL raw_done: got nf %b/%0d/%0d fw cyc %0d want %b/1/2 fw 0",
               n_ctl, n_rsn, n_cyc, f_cyc, C_RUN);
      errs++;
    end
    vecs++;
    idle();
  endtask

  task automatic test_flush();
    reset_dut();
    load_r3();
    // rti in EX with a load-use match; decode is itself another load of r3
    id_rs = 3'd3; id_rs_valid = 1'b1; ex_opcode = 5'b00011;
    #1;
    if (f_ctl !== C_FLUSH) begin
      $display("FAIL fl_rti_fw: got %b want %b", f_ctl, C_FLUSH); errs++;
    end
    vecs++;
    if (n_ctl !== C_FLUSH) begin
      $display("FAIL fl_rti_nf: got %b want %b", n_ctl, C_FLUSH); errs++;
    end
    vecs++;
    step();
    ex_opcode = 5'd0; id_Reg_write = 1'b0; id_Mem_read = 1'b0; id_write_sel = 3'd0;
    #1;
    if (f_ctl !== C_RUN || f_rsn !== 2'd3 || f_cyc !== 16'd1) begin
      $display("FAIL fl_bubble_fw: got %b/%0d/%0d want %b/3/1", f_ctl, f_rsn, f_cyc, C_RUN);
      errs++;
    end
    vecs++;
    if (n_ctl !== C_HAZ) begin
      $display("FAIL fl_mem_nf: got %b want %b", n_ctl, C_HAZ); errs++;
    end
    vecs++;
    step();
    idle();
    branch_taken = 1'b1;
    #1;
    if (f_ctl !== C_FLUSH) begin
      $display("FAIL fl_branch: got %b want %b", f_ctl, C_FLUSH); errs++;
    end
    vecs++;
    step();
    branch_taken = 1'b0; ex_opcode = 5'b00010;
    #1;
    if (f_ctl !== C_FLUSH) begin
      $display("FAIL fl_siic: got %b want %b", f_ctl, C_FLUSH); errs++;
    end
    vecs++;
    step();
    ex_opcode = 5'b00001;
    #1;
    if (f_ctl !== C_RUN || f_rsn !== 2'd3 || f_cyc !== 16'd3) begin
      $display("FAIL fl_op1: got %b/%0d/%0d want %b/3/3", f_ctl, f_rsn, f_cyc, C_RUN);
      errs++;
    end
    vecs++;
    idle();
  endtask

  task automatic test_freeze();
    reset_dut();
    load_r3();
    id_rs = 3'd3; id_rs_valid = 1'b1; id_write_sel = 3'd4; id_Mem_read = 1'b0;
    mem_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      branch_taken = (c == 2);
      #1;
      if (f_ctl !== C_FREEZE) begin
        $display("FAIL fz_fw_c%0d: got %b want %b", c, f_ctl, C_FREEZE); errs++;
      end
      vecs++;
      if (n_ctl !== C_FREEZE) begin
        $display("FAIL fz_nf_c%0d: got %b want %b", c, n_ctl, C_FREEZE); errs++;
      end
      vecs++;
      step();
    end
    mem_stall = 1'b0; branch_taken = 1'b0;
    #1;
    if (f_ctl !== C_HAZ || f_rsn !== 2'd2 || f_cyc !== 16'd3) begin
      $display("FAIL fz_release_fw: got %b/%0d/%0d want %b/2/3", f_ctl, f_rsn, f_cyc, C_HAZ);
      errs++;
    end
    vecs++;
    if (n_ctl !== C_HAZ) begin
      $display("FAIL fz_release_nf: got %b want %b", n_ctl, C_HAZ); errs++;
    end
    vecs++;
    step();
    #1;
    if (f_ctl !== C_RUN || f_rsn !== 2'd1 || f_cyc !== 16'd4) begin
      $display("FAIL fz_after_fw: got %b/%0d/%0d want %b/1/4", f_ctl, f_rsn, f_cyc, C_RUN);
      errs++;
    end
    vecs++;
    idle();
  endtask

  task automatic test_back_to_back();
    reset_dut();
    id_write_sel = 3'd0; id_Reg_write = 1'b1; id_Mem_read = 1'b1;
    #1;
    step();
    id_rt = 3'd0; id_rt_valid = 1'b1; id_write_sel = 3'd1;
    #1;
    if (f_ctl !== C_HAZ) begin
      $display("FAIL b2b_r0: got %b want %b", f_ctl, C_HAZ); errs++;
    end
    vecs++;
    step();
    #1;
    if (f_ctl !== C_RUN) begin
      $display("FAIL b2b_accept: got %b want %b", f_ctl, C_RUN); errs++;
    end
    vecs++;
    step();
    id_rt_valid = 1'b0; id_rs = 3'd1; id_rs_valid = 1'b1;
    id_write_sel = 3'd0; id_Reg_write = 1'b0; id_Mem_read = 1'b0;
    #1;
    if (f_ctl !== C_HAZ) begin
      $display("FAIL b2b_r1: got %b want %b", f_ctl, C_HAZ); errs++;
    end
    vecs++;
    id_rs_valid = 1'b0;
    #1;
    if (f_ctl !== C_RUN) begin
      $display("FAIL b2b_rs_invalid: got %b want %b", f_ctl, C_RUN); errs++;
    end
    vecs++;
    idle();
  endtask

  task automatic test_sync_reset();
    reset_dut();
    load_r3();
    id_rs = 3'd3; id_rs_valid = 1'b1; id_Reg_write = 1'b0; id_Mem_read = 1'b0;
    #1;
    if (f_ctl !== C_HAZ) begin
      $display("FAIL srst_pre: got %b want %b", f_ctl, C_HAZ); errs++;
    end
    vecs++;
    rst = 1'b1;
    #1;
    if (f_ctl !== C_RUN || n_ctl !== C_RUN) begin
      $display("FAIL srst_forced: got fw %b nf %b want %b", f_ctl, n_ctl, C_RUN); errs++;
    end
    vecs++;
    step();
    rst = 1'b0;
    #1;
    if (f_ctl !== C_RUN || n_ctl !== C_RUN || f_rsn !== 2'd0 || f_cyc !== 16'd0) begin
      $display("FAIL srst_post: got fw %b nf %b rsn %0d cyc %0d want %b %b 0 0",
               f_ctl, n_ctl, f_rsn, f_cyc, C_RUN, C_RUN);
      errs++;
    end
    vecs++;
    idle();
  endtask

  task automatic test_saturation();
    reset_dut();
    mem_stall = 1'b1;
    repeat (65534) step();
    if (f_cyc !== 16'hFFFE) begin
      $display("FAIL sat_fffe: got %h want fffe", f_cyc); errs++;
    end
    vecs++;
    step();
    if (f_cyc !== 16'hFFFF) begin
      $display("FAIL sat_ffff: got %h want ffff", f_cyc); errs++;
    end
    vecs++;
    step();
    step();
    if (f_cyc !== 16'hFFFF || n_cyc !== 16'hFFFF || f_rsn !== 2'd2) begin
      $display("FAIL sat_hold: got fw %h nf %h rsn %0d want ffff ffff 2", f_cyc, n_cyc, f_rsn);
      errs++;
    end
    vecs++;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_alu_raw();
    test_flush();
    test_freeze();
    test_back_to_back();
    test_sync_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
